// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ requesters share the single write port
// of an asynchronous FIFO, entirely in the write clock domain. A requester
// keeps the grant for a whole packet (up to MAX_BURST words), so its words land
// in the FIFO contiguously. Every release spends one IDLE cycle before the next
// arbitration.
//
// Ports:
//   wclk       write-domain clock
//   wrst       asynchronous active-high reset
//   req_valid  per-requester word valid
//   req_last   per-requester last-word-of-packet flag (qualified by req_valid)
//   req_data   packed requester words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  per-requester accept; a word moves on req_valid[i] & req_ready[i]
//   wfull      FIFO full flag (write domain)
//   winc       FIFO write enable, never high while wfull is high
//   wdata      FIFO write data
//   grant_id   index of the current or most recent grant
//   busy       high while a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          wfull,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
);

   localparam int IDW  = $clog2(NUM_REQ);
   localparam int CNTW = $clog2(MAX_BURST) + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  rr_ptr_nxt;
   logic [IDW-1:0]  grant_nxt;
   logic [CNTW-1:0] beat_cnt;
   logic [CNTW-1:0] beat_nxt;
   logic            pick_found;
   logic [IDW-1:0]  pick_idx;
   logic            xfer;

   // Returns {found, index} of the first valid requester scanning upward from
   // ptr+1 with wrap. The scan runs from the farthest candidate to the nearest
   // so the nearest valid one is the last to overwrite the result.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [IDW-1:0]     ptr);
      logic [IDW:0] res;
      int           idx;
      res = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (valid[idx]) begin
            res = {1'b1, IDW'(idx)};
         end
      end
      return res;
   endfunction

   assign {pick_found, pick_idx} = rr_pick(req_valid, rr_ptr);
   assign busy = (state == GRANT);

   // Next-state and combinational outputs
   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant_id;
      rr_ptr_nxt = rr_ptr;
      beat_nxt   = beat_cnt;
      req_ready  = '0;
      winc       = 1'b0;
      wdata      = '0;
      xfer       = 1'b0;

      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt  = GRANT;
               grant_nxt  = pick_idx;
               rr_ptr_nxt = pick_idx;
               beat_nxt   = '0;
            end
         end

         GRANT: begin
            req_ready[grant_id] = ~wfull;
            xfer                = req_valid[grant_id] & ~wfull;
            winc                = xfer;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (int'(grant_id) == i) begin
                  wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
               end
            end
            // Without a transfer (stall or full) the grant and count are held.
            // The count is cleared on release so it never exceeds MAX_BURST-1.
            if (xfer) begin
               if (req_last[grant_id] || (beat_cnt == CNTW'(MAX_BURST - 1))) begin
                  state_nxt = IDLE;
                  beat_nxt  = '0;
               end else begin
                  beat_nxt  = beat_cnt + 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register; rr_ptr starts at the top index so requester 0 wins first
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state    <= IDLE;
         grant_id <= '0;
         rr_ptr   <= IDW'(NUM_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Scoreboard bench for fifo_wr_arbiter. Requester sources hold packet queues
// and present words with random valid gaps; wfull is randomized. A
// transaction-level reference model (priority list rotated after each grant,
// word count per grant) predicts every cycle's outputs and pushes each expected
// FIFO write into a scoreboard queue; an independent monitor pops and compares
// whenever the DUT asserts winc.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;
   localparam int IDW       = $clog2(NUM_REQ);

   logic                  wclk = 1'b0;
   logic                  wrst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ*DW-1:0] req_data;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  wfull;
   logic                  winc;
   logic [DW-1:0]         wdata;
   logic [IDW-1:0]        grant_id;
   logic                  busy;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DW),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .wclk     (wclk),
      .wrst     (wrst),
      .req_valid(req_valid),
      .req_last (req_last),
      .req_data (req_data),
      .req_ready(req_ready),
      .wfull    (wfull),
      .winc     (winc),
      .wdata    (wdata),
      .grant_id (grant_id),
      .busy     (busy)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   typedef struct {
      int            cyc;
      int            id;
      logic [DW-1:0] data;
   } exp_t;

   word_t srcq [NUM_REQ][$];
   exp_t  sbq[$];

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int vprob  = 100;
   int fprob  = 0;
   bit gen_en = 1'b0;
   bit chk_en = 1'b0;

   // Reference model state: current holder (-1 when idle), words moved in this
   // grant, most recent grant and the priority list (first entry = highest).
   int m_holder, m_words, m_gid;
   int m_order[$];
   int n_holder, n_words, n_gid;
   int n_order[$];

   logic               exp_busy;
   logic               exp_winc;
   logic [NUM_REQ-1:0] exp_ready;
   int                 exp_gid;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, req);
      end
   endtask

   task automatic model_reset();
      m_holder = -1;
      m_words  = 0;
      m_gid    = 0;
      m_order.delete();
      for (int i = 0; i < NUM_REQ; i++) m_order.push_back(i);
   endtask

   task automatic add_pkt(input int id, input int len);
      for (int w = 0; w < len; w++) begin
         word_t x;
         x.data = DW'($urandom);
         x.last = (w == len - 1);
         srcq[id].push_back(x);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < NUM_REQ; i++) if (srcq[i].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive_inputs();
      logic [NUM_REQ-1:0]    v;
      logic [NUM_REQ-1:0]    l;
      logic [NUM_REQ*DW-1:0] d;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gen_en && srcq[i].size() == 0 && $urandom_range(99) < 8)
            add_pkt(i, $urandom_range(1, 7));
      end
      v = '0;
      l = NUM_REQ'($urandom);
      d = {NUM_REQ{DW'($urandom)}} ^ NUM_REQ*DW'($urandom);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (srcq[i].size() != 0 && $urandom_range(99) < vprob) begin
            v[i]             = 1'b1;
            l[i]             = srcq[i][0].last;
            d[i*DW +: DW]    = srcq[i][0].data;
         end
      end
      req_valid = v;
      req_last  = l;
      req_data  = d;
      wfull     = ($urandom_range(99) < fprob);
   endtask

   // Predicts this cycle's outputs from the driven inputs and the model state.
   task automatic model_eval();
      bit   found;
      int   g;
      exp_t e;
      exp_busy  = (m_holder >= 0);
      exp_ready = '0;
      exp_winc  = 1'b0;
      exp_gid   = m_gid;
      n_holder  = m_holder;
      n_words   = m_words;
      n_gid     = m_gid;
      n_order   = m_order;
      found     = 1'b0;
      g         = 0;
      if (m_holder < 0) begin
         foreach (m_order[k]) begin
            if (!found && req_valid[m_order[k]]) begin
               found = 1'b1;
               g     = m_order[k];
            end
         end
         if (found) begin
            n_holder = g;
            n_words  = 0;
            n_gid    = g;
            n_order.delete();
            for (int j = 1; j <= NUM_REQ; j++) n_order.push_back((g + j) % NUM_REQ);
         end
      end else begin
         exp_ready[m_holder] = !wfull;
         if (req_valid[m_holder] && !wfull) begin
            exp_winc = 1'b1;
            e.cyc    = cyc;
            e.id     = m_holder;
            e.data   = req_data[m_holder*DW +: DW];
            sbq.push_back(e);
            n_words  = m_words + 1;
            if (req_last[m_holder] || n_words == MAX_BURST) n_holder = -1;
         end
      end
   endtask

   task automatic model_commit();
      m_holder = n_holder;
      m_words  = n_words;
      m_gid    = n_gid;
      m_order  = n_order;
   endtask

   task automatic run_cycles(input int n);
      logic [NUM_REQ-1:0] hs;
      for (int c = 0; c < n; c++) begin
         @(negedge wclk);
         drive_inputs();
         #1;
         model_eval();
         chk_en = 1'b1;
         hs     = req_valid & req_ready;
         @(posedge wclk);
         chk_en = 1'b0;
         for (int i = 0; i < NUM_REQ; i++) if (hs[i]) void'(srcq[i].pop_front());
         model_commit();
         cyc++;
      end
   endtask

   task automatic drain();
      int t;
      t     = 0;
      vprob = 100;
      fprob = 10;
      while ((pending() || m_holder >= 0) && t < 3000) begin
         run_cycles(1);
         t++;
      end
      check("drain_done", 32'(t < 3000), 32'd1);
      fprob = 0;
   endtask

   // Monitor: per-cycle output checks plus scoreboard pop on every FIFO write
   always @(negedge wclk) begin
      exp_t e;
      #2;
      if (chk_en) begin
         check("winc_while_full", 32'(winc & wfull), 32'd0);
         check("winc", 32'(winc), 32'(exp_winc));
         check("busy", 32'(busy), 32'(exp_busy));
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("grant_id", 32'(grant_id), exp_gid);
         if (winc) begin
            if (sbq.size() == 0) begin
               check("unexpected_write", 32'(winc), 32'd0);
            end else begin
               e = sbq.pop_front();
               check("write_cycle", cyc, e.cyc);
               check("write_id", 32'(grant_id), e.id);
               check("write_data", 32'(wdata), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish (compared %0d)", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      wrst      = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      wfull     = 1'b0;
      model_reset();

      // Reset state, with requests present to show reset dominates
      @(negedge wclk);
      req_valid = '1;
      req_last  = '1;
      req_data  = '1;
      @(negedge wclk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_winc", 32'(winc), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_wdata", 32'(wdata), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      wrst      = 1'b0;

      // Two single-word requesters: 0 then 2 with a bubble between
      add_pkt(0, 1);
      add_pkt(2, 1);
      run_cycles(6);

      // All four requesters, single-word packets
      for (int i = 0; i < NUM_REQ; i++) begin
         add_pkt(i, 1);
         add_pkt(i, 1);
      end
      run_cycles(20);

      // Packet longer than the burst cap interleaved with another requester
      add_pkt(1, 6);
      add_pkt(3, 2);
      run_cycles(20);

      // Backpressure during a burst
      add_pkt(2, 4);
      fprob = 40;
      run_cycles(30);
      fprob = 0;
      drain();

      // Two-word packet from req0, then req0 and req1 compete: req1 first
      add_pkt(0, 2);
      run_cycles(6);
      add_pkt(0, 1);
      add_pkt(1, 1);
      run_cycles(8);

      // Randomized traffic with stalls and full
      gen_en = 1'b1;
      vprob  = 70;
      fprob  = 20;
      run_cycles(1500);
      gen_en = 1'b0;
      drain();

      // Reset during the second word of a four-word burst
      vprob = 100;
      fprob = 0;
      add_pkt(0, 4);
      t = 0;
      while (!(m_holder == 0 && m_words == 1) && t < 20) begin
         run_cycles(1);
         t++;
      end
      check("rst_setup", 32'(t < 20), 32'd1);
      #2;
      check("pre_rst_busy", 32'(busy), 32'd1);
      wrst = 1'b1;
      #1;
      check("async_rst_winc", 32'(winc), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_req_ready", 32'(req_ready), 32'd0);
      @(negedge wclk);
      @(negedge wclk);
      wrst      = 1'b0;
      req_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) srcq[i].delete();
      model_reset();

      // Requester 0 has priority again after reset
      add_pkt(2, 1);
      add_pkt(0, 1);
      run_cycles(8);
      drain();

      check("scoreboard_empty", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
